adaptive_pe_stream: RTL and testbench
=====================================

Name: adaptive_pe_stream

Overview:
- Parametrised, pipelined successor of the multi-precision processing element.
- Computes masked dot products over a stream of DATA_WIDTH-bit vectors in 1/2/4/8-bit precision, unsigned or signed.
- Accumulates each vector group into a saturating accumulator and emits one result per group over a valid/ready handshake.
- Sits between the operand buffers and the layer post-processing stage. Zero-skip uses a pipeline enable, not a gated clock.

Parameters:
- DATA_WIDTH, 64, operand vector width in bits; a multiple of 8, minimum 8.
- ACC_WIDTH, 24, signed accumulator and result width.
- CNT_WIDTH, 16, width of the beat and skip counters.

Ports:
- clk  in  1  clock.
- reset_n  in  1  active-low reset.
- clear  in  1  flush: drops in-flight beats, clears the accumulator and the held result.
- precision_mode  in  3  000=1b, 001=2b, 010=4b, 011=8b; other codes are treated as 1b.
- signed_mode  in  1  lanes are two's complement (2/4/8b only; ignored in 1b).
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_last  in  1  final beat of the group.
- weight_in  in  DATA_WIDTH  packed weights.
- activation_in  in  DATA_WIDTH  packed activations.
- mask_in  in  DATA_WIDTH  bit mask; masked-off bits are forced to 0.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_result  out  ACC_WIDTH  signed group sum.
- out_count  out  CNT_WIDTH  beats in the group (saturating).
- out_skipped  out  CNT_WIDTH  zero-skipped beats in the group (saturating).
- out_sat  out  1  accumulator saturated at some point during the group.

Behaviour:
- Reset: one clock, synchronous, active-low; this is decided.
  - While reset_n=0, all registers clear: out_valid=0, out_result=0, out_count=0, out_skipped=0, out_sat=0, pipeline empty, accumulator 0.
  - in_ready=1 from the first cycle after reset_n rises.
  - reset_n low mid-group discards the partial group.
- clear=1: same effect as reset on the next edge. reset_n has priority over clear.
- Stall: stall = out_valid && !out_ready. in_ready = !stall. While stalled, every pipeline register holds.
- Mode latching: precision_mode and signed_mode are sampled on the first accepted beat of a group and held until its last beat. Changes mid-group are ignored.
- Stage 1 (edge of acceptance): register the lane partial sum and the skip flag.
  - Operands are first ANDed with mask_in.
  - 1b: popcount(~(w^a) & mask).
  - 2/4/8b: sum over DATA_WIDTH/P lanes of w_lane*a_lane, where P is the lane width; signed or unsigned per the latched mode.
  - Skip (2/4/8b only): if the masked weight or the masked activation is all-zero, the contribution is 0 and skip=1. 1b never skips.
- Stage 2: acc_next = acc + psum, computed at full precision.
  - If acc_next > 2^(ACC_WIDTH-1)-1 or acc_next < -2^(ACC_WIDTH-1), clamp to that bound and set the sticky sat flag.
  - The beat counter and skip counter increment and saturate at all-ones.
- Group end: on a last beat, stage 2 loads out_result/out_count/out_skipped/out_sat from the next-state values and sets out_valid. Accumulator, counters and sat reset to 0 on the same edge.
  - Back-to-back groups run at full rate.
- Latency and throughput: a last beat accepted at edge k gives out_valid=1 after edge k+2. Throughput is one beat per cycle.
- Output handshake: out_valid drops on an edge where out_ready=1, unless a new result loads on that same edge, in which case it stays 1 with the new data.
- Single-beat group (in_last on the first beat) is legal. A group of all-skipped beats gives result 0.

Decomposition:
- Package adaptive_pe_pkg holds:
  - precision enum (PREC_1B, PREC_2B, PREC_4B, PREC_8B).
  - function lanes(prec, DATA_WIDTH).
  - constant PSUM_W = 17 + $clog2(DATA_WIDTH/8) + 1 (signed partial-sum width).
  - saturation bound helpers.
- Sub-module mp_lane_reduce: combinational masked multiply/popcount-reduce plus zero detect, returning a signed PSUM_W partial sum. It is instantiated once, ahead of the stage-1 register.

Test Plan:
- 1b, DATA_WIDTH=64: w=all ones, a=0x00000000FFFFFFFF, mask all ones, one beat with last -> out_result=32, out_count=1, out_skipped=0, out_sat=0, two cycles after acceptance.
- 8b unsigned: every byte w=0x02, a=0x03, three beats, last on the third -> out_result=144, out_count=3. precision_mode toggled to 01 on beat 2 has no effect.
- 4b signed: nibbles w=0xF, a=0x7, one beat -> out_result=-112 (0xFFFF90), out_sat=0. The same vectors unsigned give 1680.
- 8b unsigned saturation: w=a=all 0xFF.
  - 16 beats -> out_result=8323200, out_sat=0.
  - 17 beats -> out_result=8388607, out_sat=1.
  - The following group starts from 0.
- 2b zero-skip: three beats.
  - Beat 1: w=0x5555..., a=all ones.
  - Beat 2: w=0.
  - Beat 3: mask=0.
  - Expected -> out_result=96, out_count=3, out_skipped=2.
- Backpressure and reset:
  - Hold out_ready=0 with a result pending -> in_ready=0 and the second group's beats are held; release -> both results arrive in order and intact.
  - Assert reset_n=0 mid-group -> all outputs 0; a next group of one 1b beat with w=a=0 and mask=0xFF -> out_result=8.

Source files
------------

// File: rtl/adaptive_pe_pkg.sv
// Shared types and helpers for the adaptive multi-precision PE stream.
// Precision decode, lane geometry, partial-sum width and accumulator bounds.
package adaptive_pe_pkg;

    typedef enum logic [1:0] {
        PREC_1B = 2'd0,
        PREC_2B = 2'd1,
        PREC_4B = 2'd2,
        PREC_8B = 2'd3
    } prec_t;

    // Reserved codes 100..111 fall back to binary mode.
    function automatic prec_t decode_prec(input logic [2:0] code);
        case (code)
            3'b001:  return PREC_2B;
            3'b010:  return PREC_4B;
            3'b011:  return PREC_8B;
            default: return PREC_1B;
        endcase
    endfunction

    function automatic int prec_bits(input prec_t prec);
        case (prec)
            PREC_2B: return 2;
            PREC_4B: return 4;
            PREC_8B: return 8;
            default: return 1;
        endcase
    endfunction

    function automatic int lanes(input prec_t prec, input int data_width);
        return data_width / prec_bits(prec);
    endfunction

    function automatic int psum_width(input int data_width);
        return 17 + $clog2(data_width / 8) + 1;
    endfunction

    localparam int PSUM_W = psum_width(64);

    function automatic longint sat_max(input int acc_width);
        return (longint'(1) <<< (acc_width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int acc_width);
        return -(longint'(1) <<< (acc_width - 1));
    endfunction

    // Interpret the low 'bits' of raw as an unsigned or two's-complement lane.
    function automatic int lane_val(input logic [7:0] raw, input int bits, input logic sgn);
        int v;
        v = int'(raw);
        if (sgn && raw[bits-1]) v = v - (1 << bits);
        return v;
    endfunction

endpackage

// File: rtl/mp_lane_reduce.sv
// Combinational masked multiply / popcount reduce with zero detect. Latency: 0.
// Backpressure: none, purely combinational.
module mp_lane_reduce
    import adaptive_pe_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int PSUM_WIDTH = psum_width(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0]        weight,
    input  logic [DATA_WIDTH-1:0]        activation,
    input  logic [DATA_WIDTH-1:0]        mask,
    input  prec_t                        prec,
    input  logic                         sgn,
    output logic signed [PSUM_WIDTH-1:0] psum,
    output logic                         skip
);

    logic [DATA_WIDTH-1:0] wm;
    logic [DATA_WIDTH-1:0] am;
    int sum1;
    int sum2;
    int sum4;
    int sum8;
    int sel;

    assign wm = weight & mask;
    assign am = activation & mask;

    always_comb begin
        sum1 = 0;
        sum2 = 0;
        sum4 = 0;
        sum8 = 0;
        for (int i = 0; i < DATA_WIDTH; i++)
            if (mask[i] && (wm[i] == am[i])) sum1 = sum1 + 1;
        for (int i = 0; i < DATA_WIDTH / 2; i++)
            sum2 = sum2 + lane_val(8'(wm[2*i +: 2]), 2, sgn) * lane_val(8'(am[2*i +: 2]), 2, sgn);
        for (int i = 0; i < DATA_WIDTH / 4; i++)
            sum4 = sum4 + lane_val(8'(wm[4*i +: 4]), 4, sgn) * lane_val(8'(am[4*i +: 4]), 4, sgn);
        for (int i = 0; i < DATA_WIDTH / 8; i++)
            sum8 = sum8 + lane_val(wm[8*i +: 8], 8, sgn) * lane_val(am[8*i +: 8], 8, sgn);

        case (prec)
            PREC_2B: sel = sum2;
            PREC_4B: sel = sum4;
            PREC_8B: sel = sum8;
            default: sel = sum1;
        endcase

        // Binary mode counts matches, so an all-zero operand is still meaningful there.
        skip = (prec != PREC_1B) && ((wm == '0) || (am == '0));
        psum = skip ? '0 : PSUM_WIDTH'(sel);
    end

endmodule

// File: rtl/adaptive_pe_stream.sv
// Streaming masked dot-product PE with saturating group accumulation. Latency: last beat at edge k -> out_valid after k+2.
// Backpressure: a held result (out_valid && !out_ready) freezes every stage and drops in_ready.
module adaptive_pe_stream
    import adaptive_pe_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ACC_WIDTH  = 24,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic [2:0]                  precision_mode,
    input  logic                        signed_mode,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    input  logic [DATA_WIDTH-1:0]       weight_in,
    input  logic [DATA_WIDTH-1:0]       activation_in,
    input  logic [DATA_WIDTH-1:0]       mask_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_result,
    output logic [CNT_WIDTH-1:0]        out_count,
    output logic [CNT_WIDTH-1:0]        out_skipped,
    output logic                        out_sat
);

    localparam int                   PSUM_WIDTH = psum_width(DATA_WIDTH);
    localparam longint               ACC_MAX    = sat_max(ACC_WIDTH);
    localparam longint               ACC_MIN    = sat_min(ACC_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    logic  stall;
    logic  accept;
    logic  in_group;
    prec_t grp_prec;
    logic  grp_sgn;
    prec_t beat_prec;
    logic  beat_sgn;

    logic signed [PSUM_WIDTH-1:0] lane_psum;
    logic                         lane_skip;

    logic                         s1_vld;
    logic                         s1_last;
    logic                         s1_skip;
    logic signed [PSUM_WIDTH-1:0] s1_psum;

    logic signed [ACC_WIDTH-1:0]  acc;
    logic [CNT_WIDTH-1:0]         cnt;
    logic [CNT_WIDTH-1:0]         skp;
    logic                         sat;

    longint                       sum_full;
    logic signed [ACC_WIDTH-1:0]  acc_nxt;
    logic [CNT_WIDTH-1:0]         cnt_nxt;
    logic [CNT_WIDTH-1:0]         skp_nxt;
    logic                         sat_nxt;

    logic                         res_vld;
    logic signed [ACC_WIDTH-1:0]  res_result;
    logic [CNT_WIDTH-1:0]         res_count;
    logic [CNT_WIDTH-1:0]         res_skipped;
    logic                         res_sat;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    // The first beat of a group uses the live mode; later beats reuse the latched one.
    assign beat_prec = in_group ? grp_prec : decode_prec(precision_mode);
    assign beat_sgn  = in_group ? grp_sgn  : signed_mode;

    mp_lane_reduce #(
        .DATA_WIDTH (DATA_WIDTH),
        .PSUM_WIDTH (PSUM_WIDTH)
    ) u_reduce (
        .weight     (weight_in),
        .activation (activation_in),
        .mask       (mask_in),
        .prec       (beat_prec),
        .sgn        (beat_sgn),
        .psum       (lane_psum),
        .skip       (lane_skip)
    );

    always_comb begin
        sum_full = longint'(acc) + longint'(s1_psum);
        acc_nxt  = ACC_WIDTH'(sum_full);
        sat_nxt  = sat;
        if (sum_full > ACC_MAX) begin
            acc_nxt = ACC_WIDTH'(ACC_MAX);
            sat_nxt = 1'b1;
        end else if (sum_full < ACC_MIN) begin
            acc_nxt = ACC_WIDTH'(ACC_MIN);
            sat_nxt = 1'b1;
        end
        cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        skp_nxt = (s1_skip && (skp != CNT_MAX)) ? skp + 1'b1 : skp;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            in_group    <= 1'b0;
            grp_prec    <= PREC_1B;
            grp_sgn     <= 1'b0;
            s1_vld      <= 1'b0;
            s1_last     <= 1'b0;
            s1_skip     <= 1'b0;
            s1_psum     <= '0;
            acc         <= '0;
            cnt         <= '0;
            skp         <= '0;
            sat         <= 1'b0;
            res_vld     <= 1'b0;
            res_result  <= '0;
            res_count   <= '0;
            res_skipped <= '0;
            res_sat     <= 1'b0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_count   <= '0;
            out_skipped <= '0;
            out_sat     <= 1'b0;
        end else if (!stall) begin
            if (accept) begin
                in_group <= !in_last;
                if (!in_group) begin
                    grp_prec <= decode_prec(precision_mode);
                    grp_sgn  <= signed_mode;
                end
                s1_last <= in_last;
                s1_skip <= lane_skip;
                s1_psum <= lane_psum;
            end
            s1_vld <= accept;

            res_vld <= 1'b0;
            if (s1_vld) begin
                if (s1_last) begin
                    res_vld     <= 1'b1;
                    res_result  <= acc_nxt;
                    res_count   <= cnt_nxt;
                    res_skipped <= skp_nxt;
                    res_sat     <= sat_nxt;
                    acc         <= '0;
                    cnt         <= '0;
                    skp         <= '0;
                    sat         <= 1'b0;
                end else begin
                    acc <= acc_nxt;
                    cnt <= cnt_nxt;
                    skp <= skp_nxt;
                    sat <= sat_nxt;
                end
            end

            // Not stalled means the current result (if any) is taken on this edge.
            out_valid <= res_vld;
            if (res_vld) begin
                out_result  <= res_result;
                out_count   <= res_count;
                out_skipped <= res_skipped;
                out_sat     <= res_sat;
            end
        end
    end

endmodule

// File: tb/tb_adaptive_pe_stream.sv
// Randomised and directed bench for adaptive_pe_stream against a lane-arithmetic group model.
module tb_adaptive_pe_stream;

    localparam int     DW   = 64;
    localparam int     AW   = 24;
    localparam int     CW   = 16;
    localparam longint AMAX = 8388607;
    localparam longint AMIN = -8388608;
    localparam longint CMAX = 65535;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 clear;
    logic [2:0]           precision_mode;
    logic                 signed_mode;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_last;
    logic [DW-1:0]        weight_in;
    logic [DW-1:0]        activation_in;
    logic [DW-1:0]        mask_in;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [AW-1:0] out_result;
    logic [CW-1:0]        out_count;
    logic [CW-1:0]        out_skipped;
    logic                 out_sat;

    always #5 clk = ~clk;

    adaptive_pe_stream #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear          (clear),
        .precision_mode (precision_mode),
        .signed_mode    (signed_mode),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_last        (in_last),
        .weight_in      (weight_in),
        .activation_in  (activation_in),
        .mask_in        (mask_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_count      (out_count),
        .out_skipped    (out_skipped),
        .out_sat        (out_sat)
    );

    typedef struct {
        logic [DW-1:0] w;
        logic [DW-1:0] a;
        logic [DW-1:0] m;
        logic [2:0]    prec;
        logic          sgn;
        logic          last;
    } beat_t;

    typedef struct {
        longint res;
        longint cnt;
        longint skp;
        longint sat;
    } res_t;

    beat_t  beat_q[$];
    res_t   exp_q[$];
    res_t   last_rx;
    int     n_checks = 0;
    int     n_errors = 0;
    int     n_rx     = 0;
    int     rdy_mode = 0;
    bit     drv_bubbles = 0;

    longint m_acc = 0;
    longint m_cnt = 0;
    longint m_skp = 0;
    bit     m_sat = 0;
    bit     m_in_grp = 0;
    logic [2:0] m_prec = 3'd0;
    logic   m_sgn = 1'b0;

    localparam logic [DW-1:0] ONES = {DW{1'b1}};

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Group value straight from the lane definitions: shift each lane out and multiply.
    function automatic longint ref_psum(input beat_t b, input logic [2:0] prec, input logic sgn,
                                        output bit skip);
        int     p;
        longint s, x, y;
        logic [DW-1:0] wm, am;
        case (prec)
            3'd1:    p = 2;
            3'd2:    p = 4;
            3'd3:    p = 8;
            default: p = 1;
        endcase
        skip = 0;
        if (p == 1) return longint'($countones(~(b.w ^ b.a) & b.m));
        wm = b.w & b.m;
        am = b.a & b.m;
        if (wm == 0 || am == 0) begin
            skip = 1;
            return 0;
        end
        s = 0;
        for (int i = 0; i < DW / p; i++) begin
            x = longint'((wm >> (i * p)) & ((64'd1 << p) - 1));
            y = longint'((am >> (i * p)) & ((64'd1 << p) - 1));
            if (sgn && x >= (longint'(1) << (p - 1))) x -= (longint'(1) << p);
            if (sgn && y >= (longint'(1) << (p - 1))) y -= (longint'(1) << p);
            s += x * y;
        end
        return s;
    endfunction

    function automatic void model_reset();
        m_acc = 0; m_cnt = 0; m_skp = 0; m_sat = 0; m_in_grp = 0;
    endfunction

    function automatic void model_accept(input beat_t b);
        bit     sk;
        longint p;
        res_t   r;
        if (!m_in_grp) begin
            m_prec = b.prec;
            m_sgn  = b.sgn;
        end
        p = ref_psum(b, m_prec, m_sgn, sk);
        m_acc += p;
        if (m_acc > AMAX) begin m_acc = AMAX; m_sat = 1; end
        if (m_acc < AMIN) begin m_acc = AMIN; m_sat = 1; end
        if (m_cnt < CMAX) m_cnt++;
        if (sk && m_skp < CMAX) m_skp++;
        m_in_grp = !b.last;
        if (b.last) begin
            r.res = m_acc; r.cnt = m_cnt; r.skp = m_skp; r.sat = longint'(m_sat);
            exp_q.push_back(r);
            model_reset();
        end
    endfunction

    task automatic push(input logic [DW-1:0] w, input logic [DW-1:0] a, input logic [DW-1:0] m,
                        input logic [2:0] p, input logic s, input logic l);
        beat_t b;
        b.w = w; b.a = a; b.m = m; b.prec = p; b.sgn = s; b.last = l;
        beat_q.push_back(b);
    endtask

    task automatic wait_accepted(input int budget);
        int n = 0;
        while (beat_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (beat_q.size() != 0) check("accept_timeout", beat_q.size(), 0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((beat_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (beat_q.size() != 0 || exp_q.size() != 0)
            check("idle_timeout", beat_q.size() + exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_last(input string tag, input longint res, input longint cnt,
                              input longint skp, input longint sat);
        check({tag, "_result"}, last_rx.res, res);
        check({tag, "_count"}, last_rx.cnt, cnt);
        check({tag, "_skipped"}, last_rx.skp, skp);
        check({tag, "_sat"}, last_rx.sat, sat);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_result"}, out_result, 0);
        check({tag, "_out_count"}, out_count, 0);
        check({tag, "_out_skipped"}, out_skipped, 0);
        check({tag, "_out_sat"}, out_sat, 0);
    endtask

    // Driver: presents the queued beats; the model sees a beat only on the edge it is taken.
    initial begin
        beat_t cur;
        in_valid = 0; in_last = 0; weight_in = 0; activation_in = 0; mask_in = 0;
        precision_mode = 0; signed_mode = 0;
        forever begin
            @(negedge clk);
            if (beat_q.size() == 0 || (drv_bubbles && $urandom_range(0, 3) == 0)) begin
                in_valid = 0;
            end else begin
                cur = beat_q[0];
                weight_in = cur.w; activation_in = cur.a; mask_in = cur.m;
                precision_mode = cur.prec; signed_mode = cur.sgn; in_last = cur.last;
                in_valid = 1;
                #1;
                if (in_ready && reset_n && !clear) begin
                    @(posedge clk);
                    model_accept(cur);
                    void'(beat_q.pop_front());
                end
            end
        end
    end

    // Monitor: owns out_ready and scores every consumed result in order.
    initial begin
        res_t e;
        out_ready = 1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1;
                1:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 0;
            endcase
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", out_result, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("result", out_result, e.res);
                    check("count", out_count, e.cnt);
                    check("skipped", out_skipped, e.skp);
                    check("sat", out_sat, e.sat);
                end
                last_rx.res = out_result;
                last_rx.cnt = out_count;
                last_rx.skp = out_skipped;
                last_rx.sat = out_sat;
                n_rx++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        int            base;
        int            nb;
        int            kind;
        logic [2:0]    gp;
        logic          gs;
        logic [DW-1:0] w, a, m;

        reset_n = 0;
        clear   = 0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset_n = 1;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);

        // Binary popcount of matches and two-edge latency.
        push(ONES, 64'h00000000FFFFFFFF, ONES, 3'b000, 0, 1);
        wait_accepted(20);
        check("lat_k0_valid", out_valid, 0);
        @(negedge clk);
        check("lat_k1_valid", out_valid, 0);
        @(negedge clk);
        check("lat_k2_valid", out_valid, 1);
        wait_idle(50);
        check_last("bin", 32, 1, 0, 0);

        // 8b unsigned; the mode change on beat 2 must be ignored.
        push({8{8'h02}}, {8{8'h03}}, ONES, 3'b011, 0, 0);
        push({8{8'h02}}, {8{8'h03}}, ONES, 3'b001, 0, 0);
        push({8{8'h02}}, {8{8'h03}}, ONES, 3'b011, 0, 1);
        wait_idle(50);
        check_last("u8", 144, 3, 0, 0);

        push({16{4'hF}}, {16{4'h7}}, ONES, 3'b010, 1, 1);
        wait_idle(50);
        check_last("s4", -112, 1, 0, 0);
        push({16{4'hF}}, {16{4'h7}}, ONES, 3'b010, 0, 1);
        wait_idle(50);
        check_last("u4", 1680, 1, 0, 0);

        for (int i = 0; i < 16; i++) push(ONES, ONES, ONES, 3'b011, 0, i == 15);
        wait_idle(100);
        check_last("sat16", 8323200, 16, 0, 0);
        for (int i = 0; i < 17; i++) push(ONES, ONES, ONES, 3'b011, 0, i == 16);
        wait_idle(100);
        check_last("sat17", 8388607, 17, 0, 1);
        push({8{8'h02}}, {8{8'h02}}, ONES, 3'b011, 0, 1);
        wait_idle(50);
        check_last("after_sat", 32, 1, 0, 0);

        push({32{2'b01}}, ONES, ONES, 3'b001, 0, 0);
        push({DW{1'b0}}, ONES, ONES, 3'b001, 0, 0);
        push(ONES, ONES, {DW{1'b0}}, 3'b001, 0, 1);
        wait_idle(50);
        check_last("skip2", 96, 3, 2, 0);

        // Held result: input stalls, both groups arrive in order once released.
        rdy_mode = 2;
        base = n_rx;
        push(ONES, ONES, ONES, 3'b000, 0, 1);
        for (int i = 0; i < 5; i++) push({8{8'h01}}, {8{8'h01}}, ONES, 3'b011, 0, i == 4);
        repeat (12) @(negedge clk);
        check("stall_out_valid", out_valid, 1);
        check("stall_out_result", out_result, 64);
        check("stall_in_ready", in_ready, 0);
        check("stall_beats_held", beat_q.size() > 0, 1);
        check("stall_no_rx", n_rx - base, 0);
        rdy_mode = 0;
        wait_idle(100);
        check("bp_rx", n_rx - base, 2);
        check_last("bp_second", 40, 5, 0, 0);

        // Reset mid-group discards the partial sum.
        for (int i = 0; i < 3; i++) push({8{8'h02}}, {8{8'h03}}, ONES, 3'b011, 0, 0);
        wait_accepted(20);
        reset_n = 0;
        model_reset();
        @(negedge clk);
        check_zero_outputs("midreset");
        reset_n = 1;
        @(negedge clk);
        check("in_ready_midreset", in_ready, 1);
        push({DW{1'b0}}, {DW{1'b0}}, 64'h00000000000000FF, 3'b000, 0, 1);
        wait_idle(50);
        check_last("post_reset", 8, 1, 0, 0);

        for (int i = 0; i < 2; i++) push(ONES, ONES, ONES, 3'b011, 0, 0);
        wait_accepted(20);
        clear = 1;
        model_reset();
        @(negedge clk);
        clear = 0;
        check_zero_outputs("clear");
        push({8{8'h01}}, {8{8'h01}}, ONES, 3'b011, 0, 1);
        wait_idle(50);
        check_last("post_clear", 8, 1, 0, 0);

        // Random groups with random backpressure and input bubbles.
        rdy_mode    = 1;
        drv_bubbles = 1;
        for (int g = 0; g < 250; g++) begin
            kind = $urandom_range(0, 39);
            gp   = 3'($urandom_range(0, 7));
            gs   = 1'($urandom_range(0, 1));
            if (kind == 0) begin
                nb = 17 + $urandom_range(0, 3);
                for (int i = 0; i < nb; i++) push(ONES, ONES, ONES, 3'b011, 0, i == nb - 1);
            end else if (kind == 1) begin
                for (int i = 0; i < 65; i++)
                    push({8{8'h80}}, {8{8'h7F}}, ONES, 3'b011, 1, i == 64);
            end else begin
                nb = $urandom_range(1, 6);
                for (int i = 0; i < nb; i++) begin
                    w = {$urandom, $urandom};
                    a = {$urandom, $urandom};
                    if ($urandom_range(0, 5) == 0) w = '0;
                    if ($urandom_range(0, 5) == 0) a = '0;
                    case ($urandom_range(0, 3))
                        0:       m = ONES;
                        3:       m = ($urandom_range(0, 2) == 0) ? '0 : ONES;
                        default: m = {$urandom, $urandom};
                    endcase
                    if (i == 0) push(w, a, m, gp, gs, nb == 1);
                    else push(w, a, m, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), i == nb - 1);
                end
            end
        end
        wait_idle(30000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
